// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: encodes ALU requests into RV32I R/I-type words and
// queues them in a small output FIFO; flags illegal requests and counts
// delivered instructions.
module alu_instr_encoder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_alu_ctrl,
    input  logic        in_imm_sel,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    input  logic        err_clr,
    output logic [15:0] instr_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          illegal;
    logic [31:0]   enc_word;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;

    // Decode the ALU control into funct3/funct7 and detect illegal requests
    always_comb begin
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        illegal = 1'b0;
        case (in_alu_ctrl)
            3'b000: funct3 = 3'b000;
            3'b001: begin
                funct3  = 3'b000;
                funct7  = 7'b0100000;
                illegal = in_imm_sel;
            end
            3'b010: funct3 = 3'b111;
            3'b011: funct3 = 3'b110;
            3'b101: funct3 = 3'b010;
            default: illegal = 1'b1;
        endcase
    end

    // Assemble the instruction word for the selected format
    always_comb begin
        if (in_imm_sel) begin
            enc_word = {in_imm, in_rs1, funct3, in_rd, OP_I};
        end else begin
            enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, OP_R};
        end
    end

    // Handshake qualifiers; ready is held low while reset is asserted
    always_comb begin
        full      = (count == CW'(DEPTH));
        in_ready  = ~full & ~reset;
        out_valid = (count != '0);
        accept    = in_valid & in_ready;
        push      = accept & ~illegal;
        pop       = out_valid & out_ready;
        out_instr = out_valid ? mem[rd_ptr] : 32'h0000_0000;
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0000_0000;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flag; a new illegal accept beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && illegal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Delivered-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= 16'h0000;
        end else if (pop) begin
            instr_count <= instr_count + 16'd1;
        end
    end

endmodule
